pcpi_issuer: RTL and testbench

PCPI_ISSUER -- requirements
Module: pcpi_issuer

---
 rtl/pcpi_issuer.sv | 118 +++++++++++
 tb/tb_pcpi_issuer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pcpi_issuer.sv
// Issues one custom instruction at a time to a PCPI co-processor and returns its result
// to the core. An illegal-instruction trap is raised if no co-processor claims the instruction in time.
module pcpi_issuer #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_insn,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_busy,
   input  logic        pcpi_ready,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_wr,
   output logic [31:0] rsp_rd,
   output logic        rsp_trap
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state, state_nxt;
   logic        rdy_en;
   logic [7:0]  cnt;
   logic        seen_busy;
   logic        accept;
   logic        tmo_hit;

   assign accept = (state == IDLE) && rdy_en && req_valid;

   // An idle WAIT cycle that brings the count to TIMEOUT; pcpi_ready outranks it.
   always_comb begin
      tmo_hit = 1'b0;
      if (!pcpi_ready && !pcpi_busy && !seen_busy && (cnt >= TMO - 8'd1))
         tmo_hit = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = WAIT;
         WAIT:    if (pcpi_ready || tmo_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // rdy_en keeps req_ready low through the reset cycle itself.
   always_comb begin
      req_ready  = (state == IDLE) && rdy_en;
      pcpi_valid = (state == WAIT);
      rsp_valid  = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pcpi_insn <= '0;
         pcpi_rs1  <= '0;
         pcpi_rs2  <= '0;
         cnt       <= '0;
         seen_busy <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_rd    <= '0;
         rsp_trap  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pcpi_insn <= req_insn;
                  pcpi_rs1  <= req_rs1;
                  pcpi_rs2  <= req_rs2;
                  cnt       <= '0;
                  seen_busy <= 1'b0;
               end
            end
            WAIT: begin
               if (pcpi_ready) begin
                  rsp_rd   <= pcpi_rd;
                  rsp_wr   <= pcpi_wr;
                  rsp_trap <= 1'b0;
               end else if (pcpi_busy) begin
                  seen_busy <= 1'b1;
               end else if (!seen_busy) begin
                  // Trap fires no later than TIMEOUT <= 255, so the count cannot wrap.
                  cnt <= cnt + 8'd1;
                  if (tmo_hit) begin
                     rsp_rd   <= '0;
                     rsp_wr   <= 1'b0;
                     rsp_trap <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_issuer.sv
// Bench for pcpi_issuer: directed vector table, randomized transactions against a
// closed-form outcome model, plus reset and mid-operation reset sequences.
module tb_pcpi_issuer;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_busy = 1'b0, pcpi_ready = 1'b0, pcpi_wr = 1'b0;
   logic [31:0] pcpi_rd = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_wr;
   logic [31:0] rsp_rd;
   logic        rsp_trap;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pcpi_issuer #(.TIMEOUT(T)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_trap(rsp_trap)
   );

   // bs/bl: busy from WAIT cycle bs for bl cycles (bl=0: never); r: WAIT cycle of pcpi_ready (0: never)
   typedef struct {
      logic [31:0] insn, rs1, rs2;
      int          bs, bl, r;
      logic [31:0] rd;
      logic        wr;
      int          hold;
      int          e_len;
      logic        e_trap;
      logic [31:0] e_rd;
      logic        e_wr;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Outcome from the rules: idle cycles before the first busy count toward the trap;
   // once busy is seen the trap can never fire; a ready on or before the trap cycle wins.
   function automatic vec_t model(input vec_t v);
      vec_t o;
      int   trap_at;
      o = v;
      trap_at = (v.bl == 0 || v.bs > T) ? T : 1000000;
      if (v.r != 0 && v.r <= trap_at) begin
         o.e_len = v.r;  o.e_trap = 1'b0; o.e_rd = v.rd; o.e_wr = v.wr;
      end else begin
         o.e_len = T;    o.e_trap = 1'b1; o.e_rd = '0;   o.e_wr = 1'b0;
      end
      return o;
   endfunction

   task automatic run_vec(input vec_t v);
      int   n;
      logic ok;
      n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         tick;
         n++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_insn = v.insn; req_rs1 = v.rs1; req_rs2 = v.rs2;
      tick;
      req_valid = 1'b0; req_insn = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
      n = 0;
      ok = 1'b1;
      while (pcpi_valid === 1'b1 && n < 300) begin
         if (pcpi_insn !== v.insn || pcpi_rs1 !== v.rs1 || pcpi_rs2 !== v.rs2) ok = 1'b0;
         if (req_ready !== 1'b0) ok = 1'b0;
         n++;
         pcpi_busy  = (v.bl > 0 && n >= v.bs && n < v.bs + v.bl);
         pcpi_ready = (n == v.r);
         pcpi_rd    = pcpi_ready ? v.rd : $urandom;
         pcpi_wr    = pcpi_ready ? v.wr : 1'($urandom);
         tick;
      end
      pcpi_busy = 1'($urandom); pcpi_ready = 1'($urandom); pcpi_wr = 1'($urandom); pcpi_rd = $urandom;
      chk("wait_len", n, v.e_len);
      chk("latched_ops", {31'd0, ok}, 32'd1);
      for (int h = 0; h <= v.hold; h++) begin
         chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("rsp_trap", {31'd0, rsp_trap}, {31'd0, v.e_trap});
         chk("rsp_rd", rsp_rd, v.e_rd);
         chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, v.e_wr});
         chk("pcpi_valid_resp", {31'd0, pcpi_valid}, 32'd0);
         chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
         if (h == v.hold) rsp_ready = 1'b1;
         else begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
         end
         tick;
      end
      rsp_ready = 1'b0;
      chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
      chk("no_early_accept", {31'd0, pcpi_valid}, 32'd0);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0; pcpi_ready = 1'b0; pcpi_busy = 1'b0;
   endtask

   initial begin
      vec_t v;
      // insn, rs1, rs2, bs, bl, r, rd, wr, hold, e_len, e_trap, e_rd, e_wr
      tbl[0] = '{32'h02B50533, 32'd6, 32'd7, 1, 3, 4, 32'd42, 1'b1, 0, 4, 1'b0, 32'd42, 1'b1};
      tbl[1] = '{32'h0000000B, 32'd1, 32'd2, 0, 0, 0, 32'h0000DEAD, 1'b1, 0, 16, 1'b1, 32'd0, 1'b0};
      tbl[2] = '{32'h02C5C533, 32'hFFFFFFF7, 32'd3, 2, 40, 42, 32'hFFFFFFFD, 1'b1, 0, 42, 1'b0, 32'hFFFFFFFD, 1'b1};
      tbl[3] = '{32'h1234000B, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 2, 32'h00000055, 1'b0, 5, 2, 1'b0, 32'h00000055, 1'b0};
      tbl[4] = '{32'h0000100B, 32'd9, 32'd8, 0, 0, 16, 32'h12345678, 1'b1, 1, 16, 1'b0, 32'h12345678, 1'b1};
      tbl[5] = '{32'h0000200B, 32'd4, 32'd5, 0, 0, 17, 32'h0000ABCD, 1'b1, 0, 16, 1'b1, 32'd0, 1'b0};
      tbl[6] = '{32'h0000300B, 32'd0, 32'd0, 17, 3, 19, 32'h00000077, 1'b1, 2, 16, 1'b1, 32'd0, 1'b0};
      tbl[7] = '{32'h0000400B, 32'd1, 32'd1, 16, 1, 30, 32'h00000099, 1'b1, 0, 30, 1'b0, 32'h00000099, 1'b1};
      tbl[8] = '{32'h0000500B, 32'd2, 32'd3, 0, 0, 1, 32'hFFFFFFFF, 1'b1, 1, 1, 1'b0, 32'hFFFFFFFF, 1'b1};

      resetn = 1'b0;
      pcpi_busy = 1'b1; pcpi_ready = 1'b1; req_valid = 1'b1;
      tick;
      tick;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_pcpi_insn", pcpi_insn, 32'd0);
      chk("rst_rsp_rd", rsp_rd, 32'd0);
      chk("rst_rsp_flags", {30'd0, rsp_wr, rsp_trap}, 32'd0);
      pcpi_busy = 1'b0; pcpi_ready = 1'b0; req_valid = 1'b0;
      resetn = 1'b1;
      tick;
      chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      for (int i = 0; i < 30; i++) begin
         v.insn = $urandom; v.rs1 = $urandom; v.rs2 = $urandom;
         v.rd = $urandom; v.wr = 1'($urandom); v.hold = $urandom_range(0, 3);
         case ($urandom_range(0, 2))
            0: begin v.bs = 0; v.bl = 0; v.r = $urandom_range(0, 20); end
            1: begin
               v.bs = $urandom_range(1, 20); v.bl = $urandom_range(1, 12);
               v.r = v.bs + v.bl + $urandom_range(0, 3);
            end
            default: begin
               v.bs = $urandom_range(1, 16); v.bl = $urandom_range(1, 5);
               v.r = $urandom_range(1, v.bs + v.bl + 2);
            end
         endcase
         run_vec(model(v));
      end

      // Reset in the third WAIT cycle abandons the instruction.
      req_valid = 1'b1; req_insn = 32'hCAFE000B; req_rs1 = 32'd1; req_rs2 = 32'd2;
      tick;
      req_valid = 1'b0;
      tick;
      tick;
      chk("midrst_in_wait", {31'd0, pcpi_valid}, 32'd1);
      resetn = 1'b0;
      tick;
      chk("midrst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_pcpi_insn", pcpi_insn, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("midrst_no_rsp", {30'd0, rsp_valid, pcpi_valid}, 32'd0);
      end
      run_vec(tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
